// File: rtl/vfpu_ctrl_package.sv
// ============================================================================
// Module      : vfpu_ctrl_package
// Description : Shared types and default sizes for the VFPU job sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vfpu_ctrl_package;

    localparam int unsigned NB_OPERANDS_DEF = 2;
    localparam int unsigned NB_STREAMS      = NB_OPERANDS_DEF + 1;
    localparam int unsigned ADDR_WIDTH_DEF  = 32;

    typedef enum logic [2:0] {
        SEQ_IDLE   = 3'd0,
        SEQ_LAUNCH = 3'd1,
        SEQ_RUN    = 3'd2,
        SEQ_NEXT   = 3'd3,
        SEQ_FINISH = 3'd4
    } vfpu_seq_state_t;

    // One base address per stream; index NB_STREAMS-1 is the sink.
    typedef logic [NB_STREAMS-1:0][ADDR_WIDTH_DEF-1:0] stream_addr_array_t;

endpackage

`default_nettype wire

// File: rtl/vfpu_job_sequencer_if.sv
// ============================================================================
// Module      : vfpu_job_sequencer_if
// Description : Control/streamer bundle around the VFPU job sequencer.
//               master = controller and streamers, slave = the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vfpu_job_sequencer_if #(
    parameter int unsigned NB_OPERANDS   = 2,
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned ITER_WIDTH    = 16,
    parameter int unsigned TIMEOUT_WIDTH = 32
);
    localparam int unsigned N_STREAMS = NB_OPERANDS + 1;

    logic                                 clear_i;
    logic                                 start_i;
    logic [ITER_WIDTH-1:0]                n_iter_i;
    logic [31:0]                          trans_size_i;
    logic [TIMEOUT_WIDTH-1:0]             timeout_i;
    logic [N_STREAMS-1:0][ADDR_WIDTH-1:0] base_addr_i;
    logic [N_STREAMS-1:0][ADDR_WIDTH-1:0] iter_stride_i;
    logic [N_STREAMS-1:0]                 stream_done_i;
    logic [N_STREAMS-1:0]                 stream_req_start_o;
    logic [N_STREAMS-1:0][ADDR_WIDTH-1:0] stream_base_addr_o;
    logic [31:0]                          trans_size_o;
    logic                                 busy_o;
    logic                                 done_o;
    logic                                 error_o;
    logic [ITER_WIDTH-1:0]                iter_cnt_o;

    modport master (
        output clear_i, start_i, n_iter_i, trans_size_i, timeout_i,
               base_addr_i, iter_stride_i, stream_done_i,
        input  stream_req_start_o, stream_base_addr_o, trans_size_o,
               busy_o, done_o, error_o, iter_cnt_o
    );

    modport slave (
        input  clear_i, start_i, n_iter_i, trans_size_i, timeout_i,
               base_addr_i, iter_stride_i, stream_done_i,
        output stream_req_start_o, stream_base_addr_o, trans_size_o,
               busy_o, done_o, error_o, iter_cnt_o
    );

endinterface

`default_nettype wire

// File: rtl/vfpu_seq_watchdog.sv
// ============================================================================
// Module      : vfpu_seq_watchdog
// Description : Cycle counter that flags when it reaches limit-1 while
//               enabled. A limit of zero disables the hit output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vfpu_seq_watchdog #(
    parameter int unsigned WIDTH = 32
) (
    input  wire logic             clk_i,
    input  wire logic             rst_ni,
    input  wire logic             clear,
    input  wire logic             enable,
    input  wire logic [WIDTH-1:0] limit,
    output logic                  hit
);

    logic [WIDTH-1:0] count;

    // Count enabled cycles; clear wins over enable.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + WIDTH'(1);
        end
    end

    // Hit on the cycle the count equals limit-1, so the limit-th enabled
    // cycle is the last one spent counting.
    assign hit = enable && (limit != '0) && (count == limit - WIDTH'(1));

endmodule

`default_nettype wire

// File: rtl/vfpu_job_sequencer.sv
// ============================================================================
// Module      : vfpu_job_sequencer
// Description : Launches all source/sink streams, waits for every done,
//               strides the base addresses and repeats n_iter times, with a
//               watchdog reporting stuck iterations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vfpu_job_sequencer
    import vfpu_ctrl_package::*;
#(
    parameter int unsigned NB_OPERANDS   = NB_STREAMS - 1,
    parameter int unsigned ADDR_WIDTH    = ADDR_WIDTH_DEF,
    parameter int unsigned ITER_WIDTH    = 16,
    parameter int unsigned TIMEOUT_WIDTH = 32
) (
    input wire logic            clk_i,
    input wire logic            rst_ni,
    vfpu_job_sequencer_if.slave bus
);

    localparam int unsigned N_STREAMS = NB_OPERANDS + 1;

    vfpu_seq_state_t                      state;
    logic [ITER_WIDTH-1:0]                n_iter;
    logic [ITER_WIDTH-1:0]                iter_cnt;
    logic [TIMEOUT_WIDTH-1:0]             timeout;
    logic [31:0]                          trans_size;
    logic [N_STREAMS-1:0][ADDR_WIDTH-1:0] base;
    logic [N_STREAMS-1:0][ADDR_WIDTH-1:0] stride;
    logic [N_STREAMS-1:0][ADDR_WIDTH-1:0] base_next;
    logic [N_STREAMS-1:0]                 mask;
    logic [N_STREAMS-1:0]                 mask_next;
    logic [N_STREAMS-1:0]                 req_start;
    logic [ITER_WIDTH-1:0]                iter_next;
    logic                                 all_done;
    logic                                 busy;
    logic                                 done;
    logic                                 error;
    logic                                 wd_clear;
    logic                                 wd_enable;
    logic                                 wd_hit;

    // Dones arriving this cycle count immediately towards completion.
    assign mask_next = mask | bus.stream_done_i;
    assign all_done  = &mask_next;
    assign iter_next = iter_cnt + ITER_WIDTH'(1);
    assign wd_clear  = bus.clear_i || (state == SEQ_LAUNCH);
    assign wd_enable = (state == SEQ_RUN);

    // Per-stream address advance, wrapping modulo 2^ADDR_WIDTH.
    for (genvar g = 0; g < N_STREAMS; g++) begin : g_base_adv
        assign base_next[g] = base[g] + stride[g];
    end

    vfpu_seq_watchdog #(
        .WIDTH (TIMEOUT_WIDTH)
    ) u_watchdog (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clear  (wd_clear),
        .enable (wd_enable),
        .limit  (timeout),
        .hit    (wd_hit)
    );

    // Job sequencing FSM; every output is a register updated with the state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= SEQ_IDLE;
            n_iter     <= '0;
            iter_cnt   <= '0;
            timeout    <= '0;
            trans_size <= '0;
            base       <= '0;
            stride     <= '0;
            mask       <= '0;
            req_start  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else if (bus.clear_i) begin
            state      <= SEQ_IDLE;
            n_iter     <= '0;
            iter_cnt   <= '0;
            timeout    <= '0;
            trans_size <= '0;
            base       <= '0;
            stride     <= '0;
            mask       <= '0;
            req_start  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            req_start <= '0;
            done      <= 1'b0;
            case (state)
                SEQ_IDLE: begin
                    if (bus.start_i) begin
                        n_iter     <= bus.n_iter_i;
                        trans_size <= bus.trans_size_i;
                        timeout    <= bus.timeout_i;
                        base       <= bus.base_addr_i;
                        stride     <= bus.iter_stride_i;
                        iter_cnt   <= '0;
                        error      <= 1'b0;
                        busy       <= 1'b1;
                        if (bus.n_iter_i == '0) begin
                            state <= SEQ_FINISH;
                            done  <= 1'b1;
                        end else begin
                            state     <= SEQ_LAUNCH;
                            req_start <= '1;
                        end
                    end
                end
                SEQ_LAUNCH: begin
                    // Dones seen while the launch pulse is out are stale.
                    mask  <= '0;
                    state <= SEQ_RUN;
                end
                SEQ_RUN: begin
                    mask <= mask_next;
                    if (all_done) begin
                        state <= SEQ_NEXT;
                    end else if (wd_hit) begin
                        state <= SEQ_FINISH;
                        error <= 1'b1;
                        done  <= 1'b1;
                    end
                end
                SEQ_NEXT: begin
                    iter_cnt <= iter_next;
                    base     <= base_next;
                    if (iter_next == n_iter) begin
                        state <= SEQ_FINISH;
                        done  <= 1'b1;
                    end else begin
                        state     <= SEQ_LAUNCH;
                        req_start <= '1;
                    end
                end
                SEQ_FINISH: begin
                    state <= SEQ_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= SEQ_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.stream_req_start_o = req_start;
    assign bus.stream_base_addr_o = base;
    assign bus.trans_size_o       = trans_size;
    assign bus.busy_o             = busy;
    assign bus.done_o             = done;
    assign bus.error_o            = error;
    assign bus.iter_cnt_o         = iter_cnt;

endmodule

`default_nettype wire

// File: tb/tb_vfpu_job_sequencer.sv
// ============================================================================
// Module      : tb_vfpu_job_sequencer
// Description : Directed scoreboard bench for vfpu_job_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vfpu_job_sequencer;
    import vfpu_ctrl_package::*;

    localparam int NS = 3;

    logic clk;
    logic rst_ni;

    vfpu_job_sequencer_if #(
        .NB_OPERANDS(2), .ADDR_WIDTH(32), .ITER_WIDTH(16), .TIMEOUT_WIDTH(32)
    ) bus ();

    vfpu_job_sequencer #(
        .NB_OPERANDS(2), .ADDR_WIDTH(32), .ITER_WIDTH(16), .TIMEOUT_WIDTH(32)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_cyc = 0;
    int last_launch_cyc = 0;
    int n_launch = 0;
    bit done_seen = 1'b0;

    stream_addr_array_t launch_q[$];
    logic [16:0]        done_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, then score any launch or done the DUT produced.
    task automatic tick();
        stream_addr_array_t e;
        logic [16:0] d;
        @(posedge clk);
        #1;
        cyc++;
        if (bus.stream_req_start_o !== 3'b000) begin
            last_launch_cyc = cyc;
            n_launch++;
            check("req_start_all", 64'(bus.stream_req_start_o), 64'(3'b111));
            if (launch_q.size() == 0) begin
                check("launch_expected", 64'(launch_q.size()), 64'd1);
            end else begin
                e = launch_q.pop_front();
                for (int j = 0; j < NS; j++)
                    check($sformatf("launch_base%0d", j), 64'(bus.stream_base_addr_o[j]), 64'(e[j]));
            end
        end
        if (bus.done_o === 1'b1) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
            check("busy_in_finish", 64'(bus.busy_o), 64'd1);
            if (done_q.size() == 0) begin
                check("done_expected", 64'(done_q.size()), 64'd1);
            end else begin
                d = done_q.pop_front();
                check("done_error", 64'(bus.error_o), 64'(d[16]));
                check("done_iter_cnt", 64'(bus.iter_cnt_o), 64'(d[15:0]));
            end
        end
    endtask

    task automatic idle_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic pulse_done(input logic [2:0] m);
        bus.stream_done_i = m;
        tick();
        bus.stream_done_i = 3'b000;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!done_seen && n < budget) begin
            tick();
            n++;
        end
        check("done_within_budget", 64'(done_seen), 64'd1);
    endtask

    // Push the expected launches/completion from an independent model, then issue start.
    task automatic start_job(input logic [15:0] n, input logic [31:0] tmo, input logic [31:0] tsz,
                             input stream_addr_array_t b, input stream_addr_array_t s,
                             input logic exp_err, input logic [15:0] exp_iters, input bit expect_done);
        stream_addr_array_t e;
        for (int k = 0; k < int'(n); k++) begin
            for (int j = 0; j < NS; j++) e[j] = b[j] + 32'(k) * s[j];
            launch_q.push_back(e);
        end
        if (expect_done) done_q.push_back({exp_err, exp_iters});
        bus.n_iter_i      = n;
        bus.timeout_i     = tmo;
        bus.trans_size_i  = tsz;
        bus.base_addr_i   = b;
        bus.iter_stride_i = s;
        bus.start_i       = 1'b1;
        done_seen         = 1'b0;
        start_cyc         = cyc;
        tick();
        bus.start_i = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},      64'(bus.busy_o), 64'd0);
        check({tag, "_done"},      64'(bus.done_o), 64'd0);
        check({tag, "_error"},     64'(bus.error_o), 64'd0);
        check({tag, "_iter_cnt"},  64'(bus.iter_cnt_o), 64'd0);
        check({tag, "_req"},       64'(bus.stream_req_start_o), 64'd0);
        check({tag, "_tsize"},     64'(bus.trans_size_o), 64'd0);
        check({tag, "_sink_base"}, 64'(bus.stream_base_addr_o[2]), 64'd0);
    endtask

    initial begin
        stream_addr_array_t b;
        stream_addr_array_t s;
        int d;
        int l;

        rst_ni            = 1'b0;
        bus.clear_i       = 1'b0;
        bus.start_i       = 1'b0;
        bus.n_iter_i      = '0;
        bus.trans_size_i  = '0;
        bus.timeout_i     = '0;
        bus.base_addr_i   = '0;
        bus.iter_stride_i = '0;
        bus.stream_done_i = '0;

        // Reset state
        tick();
        tick();
        check_all_zero("reset");
        rst_ni = 1'b1;

        // Single iteration with staggered dones
        b = {32'h3000, 32'h2000, 32'h1000};
        s = '0;
        idle_until(10);
        start_job(16'd1, 32'd0, 32'h0000_0100, b, s, 1'b0, 16'd1, 1'b1);
        check("t1_launch_cycle", 64'(last_launch_cyc), 64'd11);
        check("t1_tsize", 64'(bus.trans_size_o), 64'h100);
        idle_until(20); pulse_done(3'b001);
        idle_until(25); pulse_done(3'b010);
        idle_until(30); pulse_done(3'b100);
        wait_done(8);
        check("t1_done_cycle", 64'(done_cyc), 64'd32);
        tick();
        check("t1_idle_busy", 64'(bus.busy_o), 64'd0);
        check("t1_iter_hold", 64'(bus.iter_cnt_o), 64'd1);

        // Three iterations with strides
        s = {32'h80, 32'h40, 32'h40};
        start_job(16'd3, 32'd0, 32'h0000_0200, b, s, 1'b0, 16'd3, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick();
            pulse_done(3'b100);
            pulse_done(3'b001);
            d = cyc;
            pulse_done(3'b010);
            if (k < 2) begin
                tick();
                tick();
                check("t2_relaunch_latency", 64'(last_launch_cyc), 64'(d + 2));
            end
        end
        wait_done(6);
        check("t2_done_latency", 64'(done_cyc), 64'(d + 2));
        tick();
        check("t2_final_iter", 64'(bus.iter_cnt_o), 64'd3);
        check("t2_final_sink", 64'(bus.stream_base_addr_o[2]), 64'h3180);

        // Zero iterations: done without any launch
        l = n_launch;
        start_job(16'd0, 32'd0, 32'h10, b, s, 1'b0, 16'd0, 1'b1);
        wait_done(4);
        check("t3_done_latency_ok", 64'((done_cyc - start_cyc) >= 1 && (done_cyc - start_cyc) <= 2), 64'd1);
        tick();
        tick();
        check("t3_no_launch", 64'(n_launch), 64'(l));

        // Watchdog timeout with sink done withheld
        s = '0;
        start_job(16'd1, 32'd8, 32'h20, b, s, 1'b1, 16'd0, 1'b1);
        l = cyc;
        tick();
        pulse_done(3'b011);
        wait_done(20);
        check("t4_timeout_cycle", 64'(done_cyc), 64'(l + 9));
        tick();
        check("t4_error_sticky", 64'(bus.error_o), 64'd1);
        check("t4_idle_busy", 64'(bus.busy_o), 64'd0);

        // Done in LAUNCH ignored, repeated source-0 dones, then the rest together
        start_job(16'd1, 32'd0, 32'h30, b, s, 1'b0, 16'd1, 1'b1);
        check("t5_error_cleared", 64'(bus.error_o), 64'd0);
        pulse_done(3'b111);
        pulse_done(3'b001);
        pulse_done(3'b001);
        pulse_done(3'b001);
        tick();
        check("t5_no_early_done", 64'(done_seen), 64'd0);
        check("t5_still_busy", 64'(bus.busy_o), 64'd1);
        d = cyc;
        pulse_done(3'b110);
        wait_done(6);
        check("t5_done_latency", 64'(done_cyc), 64'(d + 2));
        tick();

        // All dones simultaneously in the first RUN cycle
        start_job(16'd1, 32'd0, 32'h40, b, s, 1'b0, 16'd1, 1'b1);
        tick();
        d = cyc;
        pulse_done(3'b111);
        wait_done(6);
        check("t5b_done_latency", 64'(done_cyc), 64'(d + 2));
        tick();

        // start_i while busy is ignored
        start_job(16'd1, 32'd0, 32'h100, b, s, 1'b0, 16'd1, 1'b1);
        tick();
        bus.n_iter_i     = 16'd5;
        bus.trans_size_i = 32'h999;
        bus.base_addr_i  = {32'hA000, 32'hB000, 32'hC000};
        bus.start_i      = 1'b1;
        tick();
        bus.start_i = 1'b0;
        check("t6_tsize_held", 64'(bus.trans_size_o), 64'h100);
        check("t6_sink_held", 64'(bus.stream_base_addr_o[2]), 64'h3000);
        pulse_done(3'b111);
        wait_done(6);
        tick();
        tick();

        // Soft clear mid-RUN
        start_job(16'd3, 32'd0, 32'h50, b, s, 1'b0, 16'd0, 1'b0);
        tick();
        pulse_done(3'b001);
        bus.clear_i = 1'b1;
        tick();
        bus.clear_i = 1'b0;
        launch_q.delete();
        check_all_zero("t7_clear");
        for (int k = 0; k < 5; k++) tick();
        check("t7_no_done", 64'(done_seen), 64'd0);

        // Address wrap modulo 2^32
        b = {32'hFFFF_FFC0, 32'h0000_0000, 32'h0000_0010};
        s = {32'h0000_0080, 32'h0000_0004, 32'h0000_0008};
        start_job(16'd2, 32'd0, 32'h60, b, s, 1'b0, 16'd2, 1'b1);
        tick();
        pulse_done(3'b111);
        tick();
        check("t8_wrap_sink", 64'(bus.stream_base_addr_o[2]), 64'h0000_0040);
        tick();
        pulse_done(3'b111);
        wait_done(6);
        tick();

        // Asynchronous reset mid-run
        b = {32'h3000, 32'h2000, 32'h1000};
        s = '0;
        start_job(16'd2, 32'd0, 32'h70, b, s, 1'b0, 16'd0, 1'b0);
        tick();
        pulse_done(3'b001);
        check("t9_busy_before", 64'(bus.busy_o), 64'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        check_all_zero("t9_async_reset");
        launch_q.delete();
        done_q.delete();
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
        check_all_zero("t9_after_reset");

        check("launch_q_drained", 64'(launch_q.size()), 64'd0);
        check("done_q_drained", 64'(done_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
